// File: rtl/dma_reg_arb_if.sv
// Register-port arbiter bundle: two requester handshakes plus the shared register-file port.
// master = arbiter view, slave = requesters and register file view.
interface dma_reg_arb_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_write;
    logic [DATA_W-1:0] reg_rdata;
    logic              busy;

    modport master (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  reg_rdata,
        output p0_gnt, p0_done, p0_rdata,
        output p1_gnt, p1_done, p1_rdata,
        output reg_addr, reg_wdata, reg_write, busy
    );

    modport slave (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output reg_rdata,
        input  p0_gnt, p0_done, p0_rdata,
        input  p1_gnt, p1_done, p1_rdata,
        input  reg_addr, reg_wdata, reg_write, busy
    );
endinterface

// File: rtl/dma_reg_arb.sv
// Two-port arbiter sharing the DMA register-file port; one access per IDLE/ACCESS/RESP pass.
// Define DMA_ARB_RR_EN for round-robin contention handling, otherwise port 0 has fixed priority.
module dma_reg_arb #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          resetn,
    dma_reg_arb_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state;
    logic   lat_we;
    logic   lat_idx;
    logic   win;

`ifdef DMA_ARB_RR_EN
    logic last_winner;

    // On contention the port that did not win last time goes first.
    always_comb begin
        win = 1'b0;
        if (bus.p0_req && bus.p1_req) begin
            win = ~last_winner;
        end else if (bus.p1_req) begin
            win = 1'b1;
        end
    end
`else
    always_comb begin
        win = 1'b0;
        if (!bus.p0_req && bus.p1_req) begin
            win = 1'b1;
        end
    end
`endif

    // gnt, done and the write strobe are pulsed by default-clearing each cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            lat_we        <= 1'b0;
            lat_idx       <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_write <= 1'b0;
            bus.p0_gnt    <= 1'b0;
            bus.p1_gnt    <= 1'b0;
            bus.p0_done   <= 1'b0;
            bus.p1_done   <= 1'b0;
            bus.p0_rdata  <= '0;
            bus.p1_rdata  <= '0;
            bus.busy      <= 1'b0;
`ifdef DMA_ARB_RR_EN
            last_winner   <= 1'b1;
`endif
        end else begin
            bus.p0_gnt    <= 1'b0;
            bus.p1_gnt    <= 1'b0;
            bus.p0_done   <= 1'b0;
            bus.p1_done   <= 1'b0;
            bus.reg_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.p0_req || bus.p1_req) begin
                        state         <= ACCESS;
                        lat_idx       <= win;
                        lat_we        <= win ? bus.p1_we : bus.p0_we;
                        bus.reg_addr  <= win ? bus.p1_addr : bus.p0_addr;
                        bus.reg_wdata <= win ? bus.p1_wdata : bus.p0_wdata;
                        bus.reg_write <= win ? bus.p1_we : bus.p0_we;
                        bus.p0_gnt    <= ~win;
                        bus.p1_gnt    <= win;
                        bus.busy      <= 1'b1;
`ifdef DMA_ARB_RR_EN
                        last_winner   <= win;
`endif
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    bus.p0_done <= ~lat_idx;
                    bus.p1_done <= lat_idx;
                    if (!lat_we) begin
                        if (lat_idx) begin
                            bus.p1_rdata <= bus.reg_rdata;
                        end else begin
                            bus.p0_rdata <= bus.reg_rdata;
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_reg_arb.sv
// Self-checking bench for dma_reg_arb: transaction-level model plus directed literal checks.
// Honours DMA_ARB_RR_EN the same way the design does.
module tb_dma_reg_arb;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic clk;
    logic resetn;

    dma_reg_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dma_reg_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file the arbiter talks to.
    logic [DATA_W-1:0] regMem [512] = '{default: '0};
    assign bus.reg_rdata = regMem[bus.reg_addr];
    always @(posedge clk) begin
        if (bus.reg_write) regMem[bus.reg_addr] <= bus.reg_wdata;
    end

    // Model: one access in flight, tracked by its age in cycles since it was accepted.
    typedef struct {
        int                port;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    txn_t              mCur;
    int                mAge;
    int                mLastWin;
    logic [DATA_W-1:0] mRdata [2];
    logic [DATA_W-1:0] mMem [512] = '{default: '0};

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mAge      = 0;
            mLastWin  = 1;
            mRdata[0] = '0;
            mRdata[1] = '0;
            mCur      = '{port: 0, we: 1'b0, addr: '0, wdata: '0};
        end else if (mAge == 0) begin
            if (bus.p0_req || bus.p1_req) begin
                int w;
                if (bus.p0_req && bus.p1_req) begin
`ifdef DMA_ARB_RR_EN
                    w = 1 - mLastWin;
`else
                    w = 0;
`endif
                end else begin
                    w = bus.p0_req ? 0 : 1;
                end
                if (w == 0) mCur = '{port: 0, we: bus.p0_we, addr: bus.p0_addr, wdata: bus.p0_wdata};
                else        mCur = '{port: 1, we: bus.p1_we, addr: bus.p1_addr, wdata: bus.p1_wdata};
                mLastWin = w;
                mAge     = 1;
            end
        end else if (mAge == 1) begin
            if (mCur.we) mMem[mCur.addr] = mCur.wdata;
            else         mRdata[mCur.port] = mMem[mCur.addr];
            mAge = 2;
        end else begin
            mAge = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle the whole output set is compared against the model.
    always @(negedge clk) begin
        checkOutput("cyc_p0_gnt",    32'(bus.p0_gnt),    32'(mAge == 1 && mCur.port == 0));
        checkOutput("cyc_p1_gnt",    32'(bus.p1_gnt),    32'(mAge == 1 && mCur.port == 1));
        checkOutput("cyc_p0_done",   32'(bus.p0_done),   32'(mAge == 2 && mCur.port == 0));
        checkOutput("cyc_p1_done",   32'(bus.p1_done),   32'(mAge == 2 && mCur.port == 1));
        checkOutput("cyc_reg_write", 32'(bus.reg_write), 32'(mAge == 1 && mCur.we));
        checkOutput("cyc_busy",      32'(bus.busy),      32'(mAge != 0));
        checkOutput("cyc_reg_addr",  32'(bus.reg_addr),  32'(mCur.addr));
        checkOutput("cyc_reg_wdata", bus.reg_wdata,      mCur.wdata);
        checkOutput("cyc_p0_rdata",  bus.p0_rdata,       mRdata[0]);
        checkOutput("cyc_p1_rdata",  bus.p1_rdata,       mRdata[1]);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input bit req, input bit we,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (port == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int grantSeq [$];
`ifdef DMA_ARB_RR_EN
    int expSeq [4] = '{0, 1, 0, 1};
`else
    int expSeq [4] = '{0, 0, 0, 0};
`endif

    initial begin
        int  p0At;
        int  p1At;
        bit  gotDone;

        resetn = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        step();
        step();
        checkOutput("rst_busy",     32'(bus.busy),      32'd0);
        checkOutput("rst_reg_addr", 32'(bus.reg_addr),  32'd0);
        checkOutput("rst_p0_rdata", bus.p0_rdata,       32'd0);
        resetn = 1'b1;
        step();

        // Port 0 write on its own.
        applyStimulus(0, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF);
        step();
        checkOutput("wr_gnt",       32'(bus.p0_gnt),    32'd1);
        checkOutput("wr_strobe",    32'(bus.reg_write), 32'd1);
        checkOutput("wr_addr",      32'(bus.reg_addr),  32'h010);
        checkOutput("wr_data",      bus.reg_wdata,      32'hDEADBEEF);
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        step();
        checkOutput("wr_done",      32'(bus.p0_done),   32'd1);
        checkOutput("wr_strobe_off",32'(bus.reg_write), 32'd0);
        step();
        checkOutput("wr_idle",      32'(bus.busy),      32'd0);

        // Port 1 reads the word back.
        applyStimulus(1, 1'b1, 1'b0, 9'h010, 32'h0);
        step();
        checkOutput("rd_gnt",       32'(bus.p1_gnt),    32'd1);
        checkOutput("rd_no_strobe", 32'(bus.reg_write), 32'd0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        step();
        checkOutput("rd_done",      32'(bus.p1_done),   32'd1);
        checkOutput("rd_data",      bus.p1_rdata,       32'hDEADBEEF);
        step();

        // Both ports hammer reads for 12 cycles.
        applyStimulus(0, 1'b1, 1'b0, 9'h010, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 9'h020, 32'h0);
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.p0_gnt) grantSeq.push_back(0);
            if (bus.p1_gnt) grantSeq.push_back(1);
        end
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        checkOutput("contend_count", 32'(grantSeq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("contend_order", (i < grantSeq.size()) ? 32'(grantSeq[i]) : 32'd99, 32'(expSeq[i]));
        end
        step();
        step();
        step();

        // Port 1 arrives while port 0's write is in ACCESS.
        p0At    = -1;
        p1At    = -1;
        gotDone = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 9'h030, 32'h12345678);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (bus.p0_gnt) begin
                p0At = i;
                applyStimulus(0, 1'b0, 1'b0, '0, '0);
                applyStimulus(1, 1'b1, 1'b0, 9'h030, 32'h0);
            end
            if (bus.p1_gnt) begin
                p1At = i;
                applyStimulus(1, 1'b0, 1'b0, '0, '0);
            end
            if (bus.p1_done) begin
                gotDone = 1'b1;
                checkOutput("late_rdata", bus.p1_rdata, 32'h12345678);
            end
        end
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        checkOutput("late_p0_at",  32'(p0At),        32'd1);
        checkOutput("late_gap",    32'(p1At - p0At), 32'd3);
        checkOutput("late_done",   32'(gotDone),     32'd1);

        // Reset in the middle of a write's ACCESS cycle.
        applyStimulus(0, 1'b1, 1'b1, 9'h040, 32'hA5A5A5A5);
        @(posedge clk);
        #2;
        checkOutput("abort_pre_strobe", 32'(bus.reg_write), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("abort_strobe", 32'(bus.reg_write), 32'd0);
        checkOutput("abort_busy",   32'(bus.busy),      32'd0);
        checkOutput("abort_gnt",    32'(bus.p0_gnt),    32'd0);
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        step();
        checkOutput("abort_no_done", 32'(bus.p0_done), 32'd0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("post_busy",  32'(bus.busy),      32'd0);
            checkOutput("post_done",  32'(bus.p0_done),   32'd0);
            checkOutput("post_write", 32'(bus.reg_write), 32'd0);
        end
        checkOutput("abort_mem", regMem[9'h040], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dma_reg_arb.md
# dma_reg_arb

Two-port arbiter that shares the DMA engine's single register-file port (9-bit word address, 32-bit data, single-cycle write strobe, combinational read data) between the host AXI-lite register bridge (port 0) and the CPU-side MMIO path (port 1). Each requester issues one read or write at a time with a req/gnt/done handshake. The arbiter serialises the accesses, drives the register port, and returns read data and a completion pulse to the winning requester. It sits between the register bridge / CPU MMIO decoder and the DMA register file.

## Interface
Parameters:
- ADDR_W, 9, register word-address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock; all state changes on rising edge
- resetn  in  1  asynchronous, active-low reset
- p0_req  in  1  port 0 request; held high until p0_gnt
- p0_we  in  1  port 0: 1 = write, 0 = read; stable while p0_req
- p0_addr  in  ADDR_W  port 0 register word address
- p0_wdata  in  DATA_W  port 0 write data
- p0_gnt  out  1  port 0 request accepted (1-cycle pulse)
- p0_done  out  1  port 0 access complete (1-cycle pulse)
- p0_rdata  out  DATA_W  port 0 read data; valid with p0_done on reads
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata: same as port 0, for port 1
- reg_addr  out  ADDR_W  register-file address
- reg_wdata  out  DATA_W  register-file write data
- reg_write  out  1  register-file write strobe
- reg_rdata  in  DATA_W  register-file read data, combinational from reg_addr
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, select a winner and latch its we/addr/wdata and index. Next state is ACCESS. Otherwise remain in IDLE.
- ACCESS: gnt[winner]=1. reg_addr/reg_wdata come from the latch. reg_write equals the latched we. Winner rdata register loads reg_rdata when the latched we=0. Next state is RESP.
- RESP: done[winner]=1. Next state is IDLE.
- A write leaves the winner's rdata unchanged. The non-winner's outputs stay 0 for gnt/done, and its rdata holds its previous value.
- Arbitration, only when both reqs are high: see Configuration. A single requester always wins.
- The requester must drop req (or present a new command) no later than the cycle after gnt. A req still high at the next IDLE is treated as a new request.
- reg_write is never asserted outside ACCESS. reg_addr/reg_wdata hold their latched values between accesses.
- Reset: state=IDLE, latch=0, last_winner=1. All outputs are 0: gnt, done, reg_write, reg_addr, reg_wdata, p0_rdata, p1_rdata, busy. Reset asserted mid-access aborts it immediately. No done is issued, and the write strobe drops asynchronously.

## Timing
- Cycle 0 (IDLE): req sampled.
- Cycle 1 (ACCESS): gnt pulse; register write takes effect at the end of this cycle.
- Cycle 2 (RESP): done pulse; rdata valid.
- Cycle 3 (IDLE): next request can be sampled.
- Latency: 3 cycles from req to done-deasserted-and-idle. Sustained throughput is one access per 3 cycles.
- gnt and done are registered-state decodes, never combinational from req.
- rdata stays stable from done until that port's next read completes.

## Configuration
- DMA_ARB_RR_EN defined: round-robin arbitration. On contention the port that is not last_winner wins. last_winner updates on every grant, with or without contention.
- DMA_ARB_RR_EN undefined: fixed priority. Port 0 always wins contention; last_winner is not implemented.

## Test plan
- Port 0 writes addr 0x010 data 0xDEADBEEF alone:
  - reg_write=1 with reg_addr=0x010 and reg_wdata=0xDEADBEEF for exactly one cycle, one cycle after req.
  - p0_gnt, then p0_done, on consecutive cycles.
- Port 1 reads addr 0x010 with a register model returning the stored word: p1_done with p1_rdata=0xDEADBEEF on cycle 2; reg_write stays 0.
- Both ports continuously request reads for 12 cycles:
  - With RR_EN, grants alternate 0,1,0,1 (port 0 first after reset).
  - Without RR_EN, all 4 grants go to port 0.
- Port 0 write in flight, port 1 requests during ACCESS: port 1 is sampled at the following IDLE, so its gnt arrives 3 cycles after port 0's gnt.
- resetn driven low during ACCESS of a write:
  - reg_write and busy go 0 without waiting for a clock edge, and no done is issued.
  - After release with no req, the FSM stays IDLE and all outputs remain 0.
